vga_scanout: RTL
================

# vga_scanout

Scan-out engine that reads the 640x480 framebuffer and drives the ADV7123 DAC and VGA connector. Painter logic writes `x`/`y`/`color`/`write` into the framebuffer. This block sits on the opposite port of the framebuffer RAM. It generates 640x480@60 Hz timing from CLOCK_50 and issues sequential read addresses. It converts 9-bit RRRGGGBBB pixels to 8-bit-per-channel DAC outputs with aligned sync and blank.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixel ticks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- COLOR_DEPTH, 9, framebuffer pixel width; 3 bits per channel

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- resetn  in  1  reset, asynchronous, active-low
- rd_en  out  1  framebuffer read strobe
- rd_addr  out  19  linear pixel address, y*640+x
- rd_data  in  9  pixel from RAM; valid ≤2 clocks after rd_en
- VGA_R / VGA_G / VGA_B  out  8 each  DAC colour
- VGA_HS / VGA_VS  out  1  syncs, active-low
- VGA_BLANK_N  out  1  high during visible pixels
- VGA_SYNC_N  out  1  tied 0
- VGA_CLK  out  1  25 MHz pixel clock to DAC
- frame_start  out  1  one-clock pulse at start of frame
- in_vblank  out  1  high while v ≥ V_ACTIVE; safe window for game updates

## Operation
- Pixel tick `pix_en` toggles every clock, giving 25 MHz.
  - All counters and pipeline stages advance only on `pix_en`.
  - VGA_CLK is a registered copy of `~pix_en`, so its rising edge falls mid-pixel.
- Counters:
  - h runs 0..799 and wraps to 0.
  - v increments when h wraps, runs 0..524, and wraps to 0.
- Stage 0, counters: active = h<640 && v<480.
  - On the tick, register rd_en=active and rd_addr=addr_cnt.
  - addr_cnt increments after each active tick.
  - addr_cnt clears to 0 when (h,v)=(799,524). No multiplier.
- Stage 1, fetch: on the next tick, capture rd_data together with the delayed active flag and delayed raw syncs.
- Stage 2, output: on the following tick, register the DAC outputs.
  - Colour expansion by bit replication: R={r,r,r[2:1]}, with the same rule for G and B.
  - When the delayed active flag is 0, RGB is forced to 0 regardless of rd_data.
- Sync timing:
  - HS low for h in 656..751.
  - VS low for v in 490..491.
  - BLANK_N = delayed active.
  - All three are delayed exactly as the colour path, so colour and syncs stay aligned.
- frame_start pulses on the clock where the counters advance to (0,0).
- in_vblank is registered from the stage-0 v.

## Timing
- Reset values:
  - Counters, addr_cnt, pix_en, rd_en, rd_addr, RGB, BLANK_N, VGA_CLK, frame_start: 0.
  - VGA_HS and VGA_VS: 1.
  - in_vblank: 0.
- First tick after reset release addresses (0,0).
- Pipeline latency is 2 pixel ticks (4 clocks) from rd_en to DAC output.
- Line period is 800 ticks (1600 clocks). Frame period is 525 lines (840 000 clocks).
- rd_addr range is 0..307199 and never exceeds 307199.
  - rd_addr holds its last value while rd_en=0.
- Reset mid-frame: all state returns immediately to reset values, and scan restarts at (0,0) with no partial output.
- RAM contract: read latency of 1 or 2 clocks. Read data is sampled only on `pix_en`.

## Structure
- Shared package `vga_timing_pkg` holds:
  - the timing constants;
  - H_TOTAL=800 and V_TOTAL=525;
  - FB_ADDR_W=19 and COLOR_DEPTH;
  - the colour-expand function.
  - The painter and fruit logic import the same package.
- One sub-module, `vga_sync_counter`: h/v counters, active flag, raw HS/VS, frame_start, in_vblank.
- The top of vga_scanout holds the address counter, the two-stage pipeline, and colour expansion.

## Test plan
- **Reset:** hold resetn=0 for 10 clocks.
  - During reset: HS=VS=1, RGB=0, BLANK_N=0, rd_en=0.
  - After release: first rd_en with rd_addr=0 on the 2nd clock.
- **Line and frame timing:**
  - HS low for 192 clocks with period 1600.
  - VS low for 3200 clocks with period 840 000.
  - BLANK_N high for 1280 clocks per visible line.
- **Address sweep over one frame:**
  - rd_addr runs 0,1,…,639 on line 0 and 640 at line 1 start.
  - Last value is 307199, then 0 on the next frame.
  - Exactly 307 200 rd_en ticks.
- **Colour path:** RAM model returns 9'b111_000_101 at address 5.
  - Output is R=8'hFF, G=8'h00, B=8'hB6.
  - It appears 2 ticks after rd_addr=5, aligned with BLANK_N=1.
- **Blanking:** RAM model returns 9'h1FF everywhere.
  - RGB=0 for h in 640..799 and all v≥480.
  - in_vblank=1 exactly for lines 480..524.
- **Mid-frame reset:** assert resetn=0 at v=200, h=300 for 3 clocks.
  - Outputs return to reset values within 1 clock.
  - The scan restarts at rd_addr=0, and frame_start pulses at the next (0,0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, framebuffer geometry and colour expansion.
// Also imported by the painter and fruit logic that write the framebuffer.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int FB_ADDR_W   = 19;
  localparam int COLOR_DEPTH = 9;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } pixel_t;

  // Bit replication maps 3'b000 to 8'h00 and 3'b111 to 8'hFF exactly.
  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical raster counters advancing on pix_en, with active/sync decode.
// frame_start and in_vblank are registered; active, syncs and frame_end are decoded from the counters.
module vga_sync_counter #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic pix_en,
  output logic active,
  output logic hs_raw,
  output logic vs_raw,
  output logic frame_end,
  output logic frame_start,
  output logic in_vblank
);

  localparam logic [9:0] H_ACT_L = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS_L  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE_L  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT_L = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS_L  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE_L  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] h;
  logic [9:0] v;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      h           <= '0;
      v           <= '0;
      frame_start <= 1'b0;
      in_vblank   <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        in_vblank <= (v >= V_ACT_L);
        if (h == H_LAST) begin
          h <= '0;
          if (v == V_LAST) begin
            v           <= '0;
            frame_start <= 1'b1;
          end else begin
            v <= v + 10'd1;
          end
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  assign active    = (h < H_ACT_L) && (v < V_ACT_L);
  assign hs_raw    = !((h >= H_SS_L) && (h < H_SE_L));
  assign vs_raw    = !((v >= V_SS_L) && (v < V_SE_L));
  assign frame_end = (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scan-out: sequential read addresses, 2-tick fetch/output pipeline, 9-bit to 24-bit DAC drive.
// rd_en to DAC output is 2 pixel ticks (4 clocks); syncs and blank ride the same delay as colour.
module vga_scanout #(
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP        = vga_timing_pkg::H_FP,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP        = vga_timing_pkg::V_FP,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP,
  parameter int COLOR_DEPTH = vga_timing_pkg::COLOR_DEPTH
) (
  input  logic                                 CLOCK_50,
  input  logic                                 resetn,
  output logic                                 rd_en,
  output logic [vga_timing_pkg::FB_ADDR_W-1:0] rd_addr,
  input  logic [COLOR_DEPTH-1:0]               rd_data,
  output logic [7:0]                           VGA_R,
  output logic [7:0]                           VGA_G,
  output logic [7:0]                           VGA_B,
  output logic                                 VGA_HS,
  output logic                                 VGA_VS,
  output logic                                 VGA_BLANK_N,
  output logic                                 VGA_SYNC_N,
  output logic                                 VGA_CLK,
  output logic                                 frame_start,
  output logic                                 in_vblank
);

  import vga_timing_pkg::*;

  logic                 pix_en;
  logic                 active;
  logic                 hs_raw;
  logic                 vs_raw;
  logic                 frame_end;
  logic [FB_ADDR_W-1:0] addr_cnt;
  logic                 hs_d0;
  logic                 vs_d0;
  logic                 act_d1;
  logic                 hs_d1;
  logic                 vs_d1;
  logic [COLOR_DEPTH-1:0] pix_d1;
  pixel_t               px;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .pix_en      (pix_en),
    .active      (active),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .frame_end   (frame_end),
    .frame_start (frame_start),
    .in_vblank   (in_vblank)
  );

  assign px         = pixel_t'(pix_d1);
  assign VGA_SYNC_N = 1'b0;

  // rd_en doubles as the stage-0 active flag; rd_addr only loads on active ticks so it holds in blanking.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pix_en      <= 1'b0;
      VGA_CLK     <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      addr_cnt    <= '0;
      hs_d0       <= 1'b1;
      vs_d0       <= 1'b1;
      act_d1      <= 1'b0;
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      pix_d1      <= '0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else begin
      pix_en  <= ~pix_en;
      VGA_CLK <= ~pix_en;
      if (pix_en) begin
        rd_en <= active;
        hs_d0 <= hs_raw;
        vs_d0 <= vs_raw;
        if (active) begin
          rd_addr <= addr_cnt;
        end
        if (frame_end) begin
          addr_cnt <= '0;
        end else if (active) begin
          addr_cnt <= addr_cnt + 1'b1;
        end

        pix_d1 <= rd_data;
        act_d1 <= rd_en;
        hs_d1  <= hs_d0;
        vs_d1  <= vs_d0;

        VGA_R       <= act_d1 ? expand3(px.r) : 8'd0;
        VGA_G       <= act_d1 ? expand3(px.g) : 8'd0;
        VGA_B       <= act_d1 ? expand3(px.b) : 8'd0;
        VGA_HS      <= hs_d1;
        VGA_VS      <= vs_d1;
        VGA_BLANK_N <= act_d1;
      end
    end
  end

endmodule
